// File: rtl/muldiv_if.sv
// Handshake and HI/LO bundle between the CPU datapath (master) and the
// iterative multiply/divide unit (slave).
interface muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] src_a;
    logic [WIDTH-1:0] src_b;
    logic             hi_wren;
    logic             lo_wren;
    logic [WIDTH-1:0] mt_data;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, src_a, src_b, hi_wren, lo_wren, mt_data,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, src_a, src_b, hi_wren, lo_wren, mt_data,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiplier / restoring divider with architectural HI/LO.
// One iteration per clock on unsigned magnitudes; signs are fixed up in a final cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic     clk,
    input  logic     rst_n,
    muldiv_if.slave  bus
);
    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t             r_state;
    logic [1:0]         r_op;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic               r_neg_q;
    logic               r_neg_r;
    logic               r_div0;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_busy;
    logic               r_done;

    logic               w_signed;
    logic               w_neg_a;
    logic               w_neg_b;
    logic [WIDTH-1:0]   w_mag_a;
    logic [WIDTH-1:0]   w_mag_b;
    logic [WIDTH:0]     w_mul_sum;
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_diff;
    logic               w_div_ok;
    logic [2*WIDTH-1:0] w_acc_next;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;
    logic [WIDTH-1:0]   w_dividend;

    // For divide, r_acc holds {partial remainder, dividend bits shifting out / quotient shifting in}.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        w_signed    = ~bus.op[0];
        w_neg_a     = w_signed & bus.src_a[WIDTH-1];
        w_neg_b     = w_signed & bus.src_b[WIDTH-1];
        w_mag_a     = w_neg_a ? (~bus.src_a + 1'b1) : bus.src_a;
        w_mag_b     = w_neg_b ? (~bus.src_b + 1'b1) : bus.src_b;

        w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_b} : '0);
        w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
        w_div_diff  = w_div_shift - {1'b0, r_b};
        w_div_ok    = ~w_div_diff[WIDTH];

        w_acc_next  = {w_mul_sum, r_acc[WIDTH-1:1]};
        if (r_op[1]) begin
            w_acc_next = {(w_div_ok ? w_div_diff[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_acc[WIDTH-2:0], w_div_ok};
        end

        w_prod_fix  = r_neg_q ? (~r_acc + 1'b1) : r_acc;
        w_quo_fix   = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
        w_rem_fix   = r_neg_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
        w_dividend  = r_neg_r ? (~r_a + 1'b1) : r_a;
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_op    <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_neg_q <= 1'b0;
            r_neg_r <= 1'b0;
            r_div0  <= 1'b0;
            r_cnt   <= '0;
            r_acc   <= '0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (bus.start) begin
                        r_op    <= bus.op;
                        r_a     <= w_mag_a;
                        r_b     <= w_mag_b;
                        r_neg_q <= w_neg_a ^ w_neg_b;
                        r_neg_r <= w_neg_a;
                        r_div0  <= bus.op[1] & (bus.src_b == '0);
                        r_cnt   <= '0;
                        r_acc   <= {{WIDTH{1'b0}}, w_mag_a};
                        r_busy  <= 1'b1;
                        r_state <= S_CALC;
                    end else begin
                        if (bus.hi_wren) r_hi <= bus.mt_data;
                        if (bus.lo_wren) r_lo <= bus.mt_data;
                    end
                end
                S_CALC: begin
                    r_acc <= w_acc_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (r_cnt == CNT_W'(WIDTH - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (!r_op[1]) begin
                        {r_hi, r_lo} <= w_prod_fix;
                    end else if (r_div0) begin
                        r_hi <= w_dividend;
                        r_lo <= '1;
                    end else begin
                        r_hi <= w_rem_fix;
                        r_lo <= w_quo_fix;
                    end
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy = r_busy;
    assign bus.done = r_done;
    assign bus.hi   = r_hi;
    assign bus.lo   = r_lo;
endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_muldiv_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    muldiv_if #(.WIDTH(W)) bus ();

    muldiv_unit #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] exp_hi, exp_lo;
    logic [31:0] pend_hi, pend_lo;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Reference result {hi, lo} from ordinary 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, m;
        logic [63:0] r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        r  = '0;
        case (o)
            2'b00: r = 64'(sa * sb);
            2'b01: r = {32'b0, a} * {32'b0, b};
            default: begin
                if (b == 32'd0) begin
                    r = {a, 32'hFFFF_FFFF};
                end else if (o == 2'b10) begin
                    q = sa / sb;
                    m = sa % sb;
                    r = {m[31:0], q[31:0]};
                end else begin
                    r = {a % b, a / b};
                end
            end
        endcase
        return r;
    endfunction

    // Called just after a falling edge; start is seen on the next rising edge.
    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit lo_w);
        logic [63:0] e;
        e            = model(o, a, b);
        pend_hi      = e[63:32];
        pend_lo      = e[31:0];
        bus.start    = 1'b1;
        bus.op       = o;
        bus.src_a    = a;
        bus.src_b    = b;
        bus.lo_wren  = lo_w;
        bus.mt_data  = 32'hDEAD_BEEF;
        @(negedge clk);
        bus.start    = 1'b0;
        bus.lo_wren  = 1'b0;
        bus.op       = 2'($urandom);
        bus.src_a    = $urandom;
        bus.src_b    = $urandom;
    endtask

    task automatic wait_done(input string tag, input int stray_at, input int mt_at);
        int cycles = 0;
        int early  = 0;
        while (bus.busy === 1'b1 && cycles < 200) begin
            if (bus.done !== 1'b0) early++;
            if (cycles == stray_at) begin
                bus.start = 1'b1;
                bus.op    = 2'b01;
                bus.src_a = $urandom;
                bus.src_b = $urandom;
            end
            if (cycles == mt_at) begin
                bus.hi_wren = 1'b1;
                bus.lo_wren = 1'b1;
                bus.mt_data = 32'h5A5A_0F0F;
            end
            @(negedge clk);
            bus.start   = 1'b0;
            bus.hi_wren = 1'b0;
            bus.lo_wren = 1'b0;
            cycles++;
            if (cycles == mt_at + 1)
                check({tag, " hi/lo held while busy"}, {bus.hi, bus.lo}, {exp_hi, exp_lo});
        end
        check({tag, " busy cycles"}, 64'(cycles), 64'd33);
        check({tag, " done while busy"}, 64'(early), 64'd0);
        check({tag, " done pulse"}, 64'(bus.done), 64'd1);
        check({tag, " result hi/lo"}, {bus.hi, bus.lo}, {pend_hi, pend_lo});
        exp_hi = pend_hi;
        exp_lo = pend_lo;
    endtask

    task automatic idle_check(input string tag);
        @(negedge clk);
        check({tag, " idle busy/done"}, 64'({bus.busy, bus.done}), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  r_o;
        logic [31:0] r_a, r_b;

        rst_n       = 1'b0;
        bus.start   = 1'b0;
        bus.op      = 2'b00;
        bus.src_a   = '0;
        bus.src_b   = '0;
        bus.hi_wren = 1'b0;
        bus.lo_wren = 1'b0;
        bus.mt_data = '0;
        exp_hi      = '0;
        exp_lo      = '0;
        repeat (3) @(negedge clk);
        check("reset busy/done", 64'({bus.busy, bus.done}), 64'd0);
        check("reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        issue(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done("multu max", -1, -1);
        // Back-to-back: start asserted during the done cycle.
        issue(2'b00, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_done("mult -3*7", -1, -1);
        idle_check("after mult");
        issue(2'b00, 32'h8000_0000, 32'h8000_0000, 1'b0);
        wait_done("mult minint^2", -1, -1);
        idle_check("gap");
        issue(2'b10, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done("div -7/2", -1, -1);
        issue(2'b11, 32'd100, 32'd7, 1'b0);
        wait_done("divu 100/7", -1, -1);
        issue(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done("div minint/-1", -1, -1);
        issue(2'b10, 32'h0000_0009, 32'h0000_0000, 1'b0);
        wait_done("div 9/0", -1, -1);
        issue(2'b11, 32'd5, 32'd0, 1'b0);
        wait_done("divu 5/0 stray start", 10, -1);
        idle_check("no queued op");

        bus.hi_wren = 1'b1;
        bus.mt_data = 32'h0000_1234;
        @(negedge clk);
        bus.hi_wren = 1'b0;
        exp_hi      = 32'h0000_1234;
        check("mthi", {bus.hi, bus.lo}, {exp_hi, exp_lo});
        bus.hi_wren = 1'b1;
        bus.lo_wren = 1'b1;
        bus.mt_data = 32'hCAFE_0001;
        @(negedge clk);
        bus.hi_wren = 1'b0;
        bus.lo_wren = 1'b0;
        exp_hi      = 32'hCAFE_0001;
        exp_lo      = 32'hCAFE_0001;
        check("mthi+mtlo", {bus.hi, bus.lo}, {exp_hi, exp_lo});

        issue(2'b11, 32'd1000, 32'd3, 1'b0);
        wait_done("mt during busy", -1, 5);
        idle_check("after mt busy");
        issue(2'b01, 32'd3, 32'd5, 1'b1);
        wait_done("start wins over mtlo", -1, -1);
        idle_check("after start+mtlo");

        issue(2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b0);
        repeat (9) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async reset busy/done", 64'({bus.busy, bus.done}), 64'd0);
        check("async reset hi/lo", {bus.hi, bus.lo}, 64'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        issue(2'b10, 32'd1000, 32'hFFFF_FFFD, 1'b0);
        wait_done("div after reset", -1, -1);

        for (int i = 0; i < 24; i++) begin
            r_o = 2'($urandom);
            r_a = $urandom;
            r_b = $urandom;
            case ($urandom_range(0, 7))
                0: r_b = 32'd0;
                1: begin r_a = 32'h8000_0000; r_b = 32'hFFFF_FFFF; end
                2: r_b = 32'($urandom_range(1, 15));
                default: ;
            endcase
            if ($urandom_range(0, 1) == 1) @(negedge clk);
            issue(r_o, r_a, r_b, 1'b0);
            wait_done($sformatf("rand%0d op%0d", i, r_o), -1, -1);
        end
        idle_check("final");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
- Iterative multi-cycle multiply/divide unit with architectural HI/LO registers for the single-cycle CPU.
- Sits directly downstream of the register file read ports.
- Consumes rdata0/rdata1 as operands and produces HI/LO values.
- The datapath returns HI/LO to the register file write port on MFHI/MFLO. The control unit stalls the PC while busy is high.

Parameters:
- WIDTH, 32, operand and HI/LO width. The iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  request a new operation. Sampled on a clk edge while idle.
- op  in  2  00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
- src_a  in  WIDTH  operand A / dividend (regfile rdata0).
- src_b  in  WIDTH  operand B / divisor (regfile rdata1).
- hi_wren  in  1  MTHI write enable.
- lo_wren  in  1  MTLO write enable.
- mt_data  in  WIDTH  MTHI/MTLO data (regfile rdata0).
- busy  out  1  operation in progress. The CPU must stall.
- done  out  1  single-cycle pulse: HI/LO were just updated by an operation.
- hi  out  WIDTH  HI register.
- lo  out  WIDTH  LO register.

Behaviour:
- Reset (rst_n low, asynchronous): state IDLE, busy=0, done=0, hi=0, lo=0, internal counter/accumulators 0. Reset mid-operation aborts the operation and discards the partial result.
- States:
  - IDLE: start=1 at edge E0 latches op, |src_a| and |src_b|, and the result signs. For the U variants, raw values are latched. Counter=0. Goes to CALC, busy=1. Operands are latched at E0 only; later input changes are ignored.
  - CALC: one iteration per edge, E1..E(WIDTH).
    - Multiply: shift-add on a 2*WIDTH product.
    - Divide: restoring, 1 quotient bit per edge, WIDTH+1-bit partial remainder.
    - Counter increments each edge. After WIDTH iterations, goes to FIX.
  - FIX (edge E(WIDTH+1)): applies sign correction and writes hi/lo. Goes to IDLE. busy=0 and done=1 for exactly one cycle.
- Latency: WIDTH+1 edges from accepting start to the hi/lo update (33 for WIDTH=32).
- Back-to-back: a start during the done cycle is accepted.
- Result rules (modular WIDTH arithmetic):
  - MULT/MULTU: {hi,lo} = full 2*WIDTH product.
  - DIV/DIVU: lo=quotient, hi=remainder. Quotient truncates toward zero. The remainder takes the sign of the dividend.
  - Divide by zero (any variant): lo=all ones, hi=src_a. Same latency, no exception.
  - Signed DIV of min-int by -1: lo=min-int (0x80000000), hi=0.
- start while busy: ignored, no queueing.
- hi_wren/lo_wren:
  - Accepted only while IDLE and start=0. Write mt_data to hi/lo on that edge.
  - Ignored while busy.
  - If start and a write enable are both high in IDLE, start wins and the write is dropped.
  - hi_wren and lo_wren both high writes both registers.
- hi/lo hold their values between operations. Only FIX or an accepted MTHI/MTLO changes them.

Test Plan:
- Reset then MULTU 0xFFFFFFFF*0xFFFFFFFF -> busy high for 33 cycles, done pulse; hi=0xFFFFFFFE, lo=0x00000001.
- MULT -3*7 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. MULT 0x80000000*0x80000000 -> hi=0x40000000, lo=0.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF. DIVU 100/7 -> lo=14, hi=2. DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
- DIVU 5/0 -> lo=0xFFFFFFFF, hi=5 after 33 cycles. Second start pulsed mid-operation -> ignored, single done.
- MTHI 0x1234 in IDLE -> hi=0x1234, lo unchanged. MTLO during busy -> lo unchanged. start+lo_wren together -> operation runs, write dropped.
- rst_n low at cycle 10 of a DIV -> busy, done, hi, lo all 0 immediately (no clk edge needed). Next start completes normally in 33 cycles.
